// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF shared definitions used by the cv32e40px offload path.
// Holds the id width and the core-side scoreboard slot types.
package cv32e40px_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    X_SB_FREE      = 2'd0,
    X_SB_ISSUED    = 2'd1,
    X_SB_COMMITTED = 2'd2
  } x_sb_state_e;

  typedef struct packed {
    x_sb_state_e           state;
    logic [X_ID_WIDTH-1:0] id;
    logic                  writeback;
    logic                  loadstore;
    logic [4:0]            rd;
  } x_sb_entry_t;

endpackage

// File: rtl/cv32e40px_x_scoreboard.sv
// Core-side scoreboard for CORE-V-XIF offloads: allocates issue ids, tracks
// accepted instructions through issue/commit/result and reports rd hazards.
module cv32e40px_x_scoreboard #(
  parameter int unsigned X_ID_WIDTH = cv32e40px_core_v_xif_pkg::X_ID_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid_i,
  input  logic                         issue_ready_i,
  input  logic                         issue_accept_i,
  input  logic                         issue_writeback_i,
  input  logic                         issue_loadstore_i,
  input  logic [4:0]                   issue_rd_i,
  output logic [X_ID_WIDTH-1:0]        issue_id_o,
  output logic                         issue_allowed_o,
  input  logic                         commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]        commit_id_i,
  input  logic                         commit_kill_i,
  input  logic                         result_valid_i,
  input  logic [X_ID_WIDTH-1:0]        result_id_i,
  output logic                         result_ready_o,
  input  logic [4:0]                   rs1_i,
  input  logic [4:0]                   rs2_i,
  input  logic [4:0]                   rs3_i,
  input  logic [4:0]                   rd_i,
  output logic                         hazard_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         empty_o,
  output logic                         err_o
);
  import cv32e40px_core_v_xif_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 1 || DEPTH > (1 << X_ID_WIDTH)) begin : g_bad_depth
    $error("cv32e40px_x_scoreboard: DEPTH must be in 1..2**X_ID_WIDTH");
  end
  if (X_ID_WIDTH != cv32e40px_core_v_xif_pkg::X_ID_WIDTH) begin : g_bad_idw
    $error("cv32e40px_x_scoreboard: X_ID_WIDTH must match the xif package");
  end

  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;
  logic                  issue_hs, alloc, found;
  logic [DEPTH-1:0]      free_vec, alloc_oh, commit_hit, result_hit, busy_d, hazard_vec;

  assign issue_hs        = issue_valid_i & issue_ready_i;
  assign issue_allowed_o = count_q < DEPTH_C;
  assign alloc           = issue_hs & issue_accept_i & issue_allowed_o;

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc && free_vec[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Matching uses pre-update slot state, so a commit and result for the same id
  // in one cycle cannot both hit: the result sees the slot still ISSUED.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    x_sb_entry_t slot_q, slot_d;
    logic        unused_ls;

    assign free_vec[g]   = slot_q.state == X_SB_FREE;
    assign commit_hit[g] = commit_valid_i && (slot_q.state == X_SB_ISSUED) &&
                           (slot_q.id == commit_id_i);
    assign result_hit[g] = result_valid_i && (slot_q.state == X_SB_COMMITTED) &&
                           (slot_q.id == result_id_i);
    assign hazard_vec[g] = !free_vec[g] && slot_q.writeback && (slot_q.rd != 5'd0) &&
                           ((slot_q.rd == rs1_i) || (slot_q.rd == rs2_i) ||
                            (slot_q.rd == rs3_i) || (slot_q.rd == rd_i));
    assign busy_d[g]     = slot_d.state != X_SB_FREE;
    assign unused_ls     = slot_q.loadstore;

    always_comb begin
      slot_d = slot_q;
      if (alloc_oh[g]) begin
        slot_d.state     = X_SB_ISSUED;
        slot_d.id        = id_q;
        slot_d.writeback = issue_writeback_i;
        slot_d.loadstore = issue_loadstore_i;
        slot_d.rd        = issue_rd_i;
      end else if (commit_hit[g]) begin
        slot_d.state = commit_kill_i ? X_SB_FREE : X_SB_COMMITTED;
      end else if (result_hit[g]) begin
        slot_d.state = X_SB_FREE;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) count_d = count_d + CW'(busy_d[i]);
  end

  assign id_d  = issue_hs ? id_q + X_ID_WIDTH'(1) : id_q;
  assign err_d = err_q | (issue_hs & ~issue_allowed_o) |
                 (commit_valid_i & ~(|commit_hit)) |
                 (result_valid_i & ~(|result_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      id_q    <= id_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign issue_id_o     = id_q;
  assign outstanding_o  = count_q;
  assign empty_o        = count_q == '0;
  assign hazard_o       = |hazard_vec;
  assign err_o          = err_q;
  assign result_ready_o = 1'b1;

endmodule

// File: tb/tb_cv32e40px_x_scoreboard.sv
// Self-checking bench for cv32e40px_x_scoreboard: vector table plus an
// id scoreboard for the wrap-around sequence.
module tb_cv32e40px_x_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0, issue_ready = 1'b0, issue_accept = 1'b0;
  logic       issue_wb = 1'b0, issue_ls = 1'b0;
  logic [4:0] issue_rd = '0;
  logic [3:0] issue_id;
  logic       issue_allowed;
  logic       commit_valid = 1'b0, commit_kill = 1'b0;
  logic [3:0] commit_id = '0;
  logic       result_valid = 1'b0;
  logic [3:0] result_id = '0;
  logic       result_ready;
  logic [4:0] rs1 = '0, rs2 = '0, rs3 = '0, rdi = '0;
  logic       hazard;
  logic [2:0] outstanding;
  logic       empty, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40px_x_scoreboard #(.X_ID_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_i(issue_ready),
    .issue_accept_i(issue_accept), .issue_writeback_i(issue_wb),
    .issue_loadstore_i(issue_ls), .issue_rd_i(issue_rd),
    .issue_id_o(issue_id), .issue_allowed_o(issue_allowed),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_i(result_valid), .result_id_i(result_id), .result_ready_o(result_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rd_i(rdi),
    .hazard_o(hazard), .outstanding_o(outstanding), .empty_o(empty), .err_o(err)
  );

  typedef struct {
    logic       rst;
    logic       iv, acc, wb;
    logic [4:0] rd;
    logic       cv;
    logic [3:0] cid;
    logic       kill;
    logic       rv;
    logic [3:0] rid;
    logic [4:0] rs;
    logic [1:0] rsel;
    logic [3:0] e_id;
    logic       e_allow;
    logic [2:0] e_out;
    logic       e_hz;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] exp_q[$];

  function automatic vec_t mk(input int rst, input int iv, input int acc, input int wb,
                              input int rd, input int cv, input int cid, input int kill,
                              input int rv, input int rid, input int rs, input int rsel,
                              input int e_id, input int e_allow, input int e_out,
                              input int e_hz, input int e_err);
    vec_t v;
    v.rst = 1'(rst);  v.iv = 1'(iv);   v.acc = 1'(acc);   v.wb = 1'(wb);
    v.rd = 5'(rd);    v.cv = 1'(cv);   v.cid = 4'(cid);   v.kill = 1'(kill);
    v.rv = 1'(rv);    v.rid = 4'(rid); v.rs = 5'(rs);     v.rsel = 2'(rsel);
    v.e_id = 4'(e_id); v.e_allow = 1'(e_allow); v.e_out = 3'(e_out);
    v.e_hz = 1'(e_hz); v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int unsigned act,
                     input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d exp=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (v.rst) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    issue_valid = v.iv;  issue_ready = v.iv; issue_accept = v.acc;
    issue_wb = v.wb;     issue_ls = 1'b0;    issue_rd = v.rd;
    commit_valid = v.cv; commit_id = v.cid;  commit_kill = v.kill;
    result_valid = v.rv; result_id = v.rid;
    rs1 = '0; rs2 = '0; rs3 = '0; rdi = '0;
    case (v.rsel)
      2'd0:    rs1 = v.rs;
      2'd1:    rs2 = v.rs;
      2'd2:    rs3 = v.rs;
      default: rdi = v.rs;
    endcase
    #1;
    chk("issue_id", idx, issue_id, v.e_id);
    chk("allowed", idx, issue_allowed, v.e_allow);
    chk("outstanding", idx, outstanding, v.e_out);
    chk("empty", idx, empty, (v.e_out == 3'd0) ? 1 : 0);
    chk("hazard", idx, hazard, v.e_hz);
    chk("err", idx, err, v.e_err);
    chk("result_ready", idx, result_ready, 1);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_ready = 1'b0; issue_accept = 1'b0;
    commit_valid = 1'b0; result_valid = 1'b0; commit_kill = 1'b0;
    rs1 = '0; rs2 = '0; rs3 = '0; rdi = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Issue, hazard, reject, fill, result-frees-slot, kill, stray result
    tbl.push_back(mk(1,0,0,0,0,  0,0,0, 0,0, 0,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,5,  0,0,0, 0,0, 0,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,6,  0,0,0, 0,0, 5,0,  1,1,1,1,0));
    tbl.push_back(mk(0,1,1,1,7,  0,0,0, 0,0, 0,0,  2,1,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 6,0,  3,1,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 8,1,  3,1,3,0,0));
    tbl.push_back(mk(0,1,0,1,9,  0,0,0, 0,0, 9,0,  3,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 9,2,  4,1,3,0,0));
    tbl.push_back(mk(0,1,1,1,10, 0,0,0, 0,0, 0,0,  4,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 10,3, 5,0,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,  1,1,0, 0,0, 0,0,  5,0,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 1,1, 0,0,  5,0,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 6,0,  5,1,3,0,0));
    tbl.push_back(mk(0,1,1,1,11, 0,0,0, 0,0, 0,0,  5,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 11,3, 6,0,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,  1,2,1, 0,0, 7,0,  6,0,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 7,0,  6,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 1,2, 5,0,  6,1,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 5,1,  6,1,3,1,1));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 11,0, 6,1,3,1,1));
    // Mid-run reset, then simultaneous commit/result cases
    tbl.push_back(mk(1,0,0,0,0,  0,0,0, 0,0, 5,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,1,  0,0,0, 0,0, 0,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,2,  0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1,1,1,3,  0,0,0, 0,0, 0,0,  2,1,2,0,0));
    tbl.push_back(mk(0,1,1,1,4,  1,1,0, 0,0, 0,0,  3,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  1,0,0, 1,1, 0,0,  4,0,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,  1,3,0, 1,3, 0,0,  4,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 1,3, 4,2,  4,1,3,1,1));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 1,0, 1,0,  4,1,2,1,1));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 1,0,  4,1,1,0,1));
    // Issue handshake while full is an error and allocates nothing
    tbl.push_back(mk(1,0,0,0,0,  0,0,0, 0,0, 0,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,  0,0,0, 0,0, 0,0,  0,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,  0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1,1,0,0,  0,0,0, 0,0, 0,0,  2,1,2,0,0));
    tbl.push_back(mk(0,1,1,0,0,  0,0,0, 0,0, 0,0,  3,1,3,0,0));
    tbl.push_back(mk(0,1,1,1,3,  0,0,0, 0,0, 3,0,  4,0,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0, 0,0, 3,0,  5,0,4,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // 17 issue/commit/result rounds: id wraps 15 -> 0 and slots are reused
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e;
      @(negedge clk);
      issue_valid = 1'b1; issue_ready = 1'b1; issue_accept = 1'b1;
      issue_wb = 1'b1; issue_rd = 5'((i % 31) + 1);
      exp_q.push_back(4'(i % 16));
      #1;
      e = exp_q.pop_front();
      chk("wrap_issue_id", 100 + i, issue_id, e);
      @(negedge clk);
      idle_inputs();
      commit_valid = 1'b1; commit_id = e;
      @(negedge clk);
      commit_valid = 1'b0;
      result_valid = 1'b1; result_id = e;
      @(negedge clk);
      result_valid = 1'b0;
      #1;
      chk("wrap_outstanding", 100 + i, outstanding, 0);
    end
    chk("wrap_err", 200, err, 0);
    chk("wrap_next_id", 200, issue_id, 1);
    chk("wrap_empty", 200, empty, 1);
    chk("wrap_allowed", 200, issue_allowed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40px_x_scoreboard.md
Name: cv32e40px_x_scoreboard

Overview:
Core-side scoreboard for CORE-V-XIF offloading in cv32e40px.
- Allocates the issue ID for each offload attempt.
- Tracks every accepted offloaded instruction through issue, commit and result.
- Reports register hazards so the ID stage can stall dependent instructions.
- Sits between the ID/EX offload controller and the X-interface issue/commit/result channels.

Parameters:
- X_ID_WIDTH, 4, width of issue/commit/result id (from cv32e40px_core_v_xif_pkg).
- DEPTH, 4, max outstanding accepted offloads. Legal range 1..2**X_ID_WIDTH; elaboration-time assertion otherwise.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  core drives x_issue_valid
- issue_ready_i  in  1  coprocessor x_issue_ready
- issue_accept_i  in  1  x_issue_resp.accept
- issue_writeback_i  in  1  x_issue_resp.writeback
- issue_loadstore_i  in  1  x_issue_resp.loadstore
- issue_rd_i  in  5  rd field of the offloaded instruction
- issue_id_o  out  X_ID_WIDTH  id to place on x_issue_req.id
- issue_allowed_o  out  1  a free slot exists; offload controller must not raise issue_valid when 0
- commit_valid_i  in  1  x_commit_valid
- commit_id_i  in  X_ID_WIDTH  x_commit.id
- commit_kill_i  in  1  x_commit.commit_kill
- result_valid_i  in  1  x_result_valid
- result_id_i  in  X_ID_WIDTH  x_result.id
- result_ready_o  out  1  x_result_ready
- rs1_i, rs2_i, rs3_i, rd_i  in  5 each  register addresses of the instruction in ID
- hazard_o  out  1  ID instruction depends on a pending offload writeback
- outstanding_o  out  $clog2(DEPTH+1)  number of occupied slots
- empty_o  out  1  no occupied slots
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset values: issue_id_o=0, all slots FREE, outstanding_o=0, empty_o=1, issue_allowed_o=1, hazard_o=0, err_o=0, result_ready_o=1.
- Issue handshake is issue_valid_i & issue_ready_i.
  - id counter increments by one per handshake, accepted or not, modulo 2**X_ID_WIDTH (15 wraps to 0).
  - issue_id_o is the registered counter value.
- Allocation happens on handshake with accept=1.
  - The lowest-index FREE slot is loaded with {id, writeback, loadstore, rd}. State becomes ISSUED.
  - No allocation when accept=0.
- Slot states: FREE, ISSUED, COMMITTED.
  - FREE -> ISSUED on allocation.
  - ISSUED -> COMMITTED on commit_valid_i with matching id and kill=0.
  - ISSUED -> FREE on matching commit with kill=1.
  - COMMITTED -> FREE on result_valid_i & result_ready_o with matching id.
- result_ready_o is constant 1. Results are accepted out of order.
- Error conditions. Each sets err_o=1 and leaves all slot states unchanged; err_o clears only on reset.
  - Commit id matching no ISSUED slot.
  - Result id matching no COMMITTED slot.
  - Issue handshake while issue_allowed_o=0.
- Timing of status outputs:
  - issue_allowed_o = (outstanding_o < DEPTH), computed from registered state only. A slot freed this cycle is visible next cycle (no bypass).
  - outstanding_o and empty_o are registered and update the cycle after the event.
- Simultaneous events in one cycle:
  - Allocation and free of different slots are both applied; count = count + 1 - frees.
  - Commit and result for the same id in the same cycle: the result is an error, because matching uses pre-update state.
  - Commit and result for different ids are both applied.
- hazard_o is combinational. It is 1 if any non-FREE slot has writeback=1, rd!=0, and rd equal to any of rs1_i/rs2_i/rs3_i/rd_i.
  - An entry allocated this cycle counts from the next cycle.
- Reset asserted mid-operation clears all slots and the id counter asynchronously. In-flight results after reset are flagged as errors.

Decomposition:
- Add to cv32e40px_core_v_xif_pkg:
  - x_sb_state_e enum {X_SB_FREE, X_SB_ISSUED, X_SB_COMMITTED}.
  - x_sb_entry_t packed struct {state, id[X_ID_WIDTH], writeback, loadstore, rd[5]}.
- The block reuses X_ID_WIDTH from the package.
- Single module; a slot is a generate-loop register, and no sub-module is needed.

Test Plan:
- Reset, then 3 accepted issues (rd=5,6,7, writeback=1) -> issue_id_o steps 0,1,2,3; outstanding_o=3; hazard_o=1 for rs1_i=6, hazard_o=0 for rs1_i=0 or 8.
- Fill DEPTH=4, then result id 1 (after commit) -> issue_allowed_o=0 while full, returns to 1 exactly one cycle after the result handshake; next allocation takes slot of id 1.
- Issue with accept=0 at id 3 -> counter advances to 4, outstanding_o unchanged, no hazard on its rd.
- Commit id 2 with kill=1 -> slot freed next cycle; a later result id 2 -> err_o=1, other slots unchanged.
- 17 accepted issue/commit/result sequences -> id wraps 15->0, slots correctly reused, err_o stays 0.
- Commit id 0 and result id 1 (previously committed) in the same cycle -> both applied; commit and result of id 3 in the same cycle -> err_o=1, id 3 remains COMMITTED.
